// File: rtl/bpsk_symbol_modulator_if.sv
// Symbol handshake between the bit source and the BPSK modulator.
// A bit moves on any cycle where sym_valid and sym_ready are both high.
interface bpsk_symbol_modulator_if;
    logic sym_valid;
    logic sym_bit;
    logic sym_ready;

    modport master (output sym_valid, output sym_bit, input sym_ready);
    modport slave  (input sym_valid, input sym_bit, output sym_ready);
endinterface

// File: rtl/bpsk_symbol_modulator.sv
// BPSK/DBPSK carrier generator: one sine-LUT DAC sample per tick, 1 clk from accept to the first sample.
// sym_ready only in IDLE or on the last tick of a symbol, so consecutive symbols stay gapless.
module bpsk_symbol_modulator #(
    parameter int DATA_WIDTH        = 12,
    parameter int LUT_ADDR_WIDTH    = 5,
    parameter int CLK_DIV           = 1,
    parameter int CYCLES_PER_SYMBOL = 4,
    parameter int DIFFERENTIAL      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    bpsk_symbol_modulator_if.slave   sym_if,
    output logic [DATA_WIDTH-1:0]    dac_out_o,
    output logic                     sample_stb_o,
    output logic                     busy_o,
    output logic                     underrun_o
);
    localparam int  LUT_N = 1 << LUT_ADDR_WIDTH;
    localparam int  DIVW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int  CYCW  = (CYCLES_PER_SYMBOL > 1) ? $clog2(CYCLES_PER_SYMBOL) : 1;
    localparam bit  DIFF  = (DIFFERENTIAL != 0);

    typedef logic [DATA_WIDTH-1:0] sample_t;
    localparam sample_t MID = sample_t'(1 << (DATA_WIDTH - 1));

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    // lut[k] = round(mid + (mid-1) * sin(2*pi*k/N)); all values are positive so +0.5 then truncate rounds
    function automatic sample_t lut_val(input int k);
        real amp;
        real ph;
        amp = real'((1 << (DATA_WIDTH - 1)) - 1);
        ph  = 2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_N);
        return sample_t'($rtoi(real'(1 << (DATA_WIDTH - 1)) + amp * $sin(ph) + 0.5));
    endfunction

    sample_t lut [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        assign lut[k] = lut_val(k);
    end

    state_t                    state_q, state_d;
    logic [DIVW-1:0]           div_q, div_d;
    logic [LUT_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CYCW-1:0]           cyc_q, cyc_d;
    logic                      inv_q, inv_d;
    logic                      diff_q, diff_d;
    sample_t                   dac_q, dac_d;
    logic                      stb_q, stb_d;
    logic                      busy_q, busy_d;
    logic                      und_q, und_d;

    logic tick, eos, ready, xfer, new_diff, new_inv, load;

    assign tick     = (div_q == DIVW'(CLK_DIV - 1));
    assign eos      = (state_q == RUN) && tick && (addr_q == '1)
                      && (cyc_q == CYCW'(CYCLES_PER_SYMBOL - 1));
    assign ready    = en_i && ((state_q == IDLE) || eos);
    assign xfer     = sym_if.sym_valid && ready;
    assign new_diff = diff_q ^ sym_if.sym_bit;
    assign new_inv  = DIFF ? new_diff : ~sym_if.sym_bit;

    assign sym_if.sym_ready = ready;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        addr_d  = addr_q;
        cyc_d   = cyc_q;
        inv_d   = inv_q;
        diff_d  = diff_q;
        dac_d   = dac_q;
        stb_d   = 1'b0;
        und_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                dac_d = MID;
                if (xfer) begin
                    state_d = RUN;
                    inv_d   = new_inv;
                    diff_d  = DIFF ? new_diff : diff_q;
                    addr_d  = '0;
                    cyc_d   = '0;
                    div_d   = '0;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (!tick) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (eos) begin
                        if (xfer) begin
                            inv_d  = new_inv;
                            diff_d = DIFF ? new_diff : diff_q;
                            addr_d = '0;
                            cyc_d  = '0;
                            load   = 1'b1;
                        end else begin
                            state_d = IDLE;
                            dac_d   = MID;
                            und_d   = en_i;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                        if (addr_q == '1) begin
                            cyc_d = cyc_q + 1'b1;
                        end
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Inverting offset-binary is a bitwise complement: (2^DW-1) - x
        if (load) begin
            dac_d = lut[addr_d] ^ {DATA_WIDTH{inv_d}};
            stb_d = 1'b1;
        end
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            addr_q  <= '0;
            cyc_q   <= '0;
            inv_q   <= 1'b0;
            diff_q  <= 1'b0;
            dac_q   <= MID;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            addr_q  <= addr_d;
            cyc_q   <= cyc_d;
            inv_q   <= inv_d;
            diff_q  <= diff_d;
            dac_q   <= dac_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            und_q   <= und_d;
        end
    end

    assign dac_out_o    = dac_q;
    assign sample_stb_o = stb_q;
    assign busy_o       = busy_q;
    assign underrun_o   = und_q;
endmodule

// File: tb/tb_bpsk_symbol_modulator.sv
// Bench for bpsk_symbol_modulator: coherent instance (CLK_DIV=1) and DBPSK instance (CLK_DIV=3).
module tb_bpsk_symbol_modulator;
    localparam int N   = 16;
    localparam int SYM = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic a_en, b_en;
    logic [11:0] a_dac, b_dac;
    logic a_stb, a_busy, a_und, b_stb, b_busy, b_und;

    bpsk_symbol_modulator_if a_if ();
    bpsk_symbol_modulator_if b_if ();

    bpsk_symbol_modulator #(.DATA_WIDTH(12), .LUT_ADDR_WIDTH(4), .CLK_DIV(1),
                            .CYCLES_PER_SYMBOL(2), .DIFFERENTIAL(0)) u_a (
        .clk(clk), .rst(rst), .en_i(a_en), .sym_if(a_if), .dac_out_o(a_dac),
        .sample_stb_o(a_stb), .busy_o(a_busy), .underrun_o(a_und));

    bpsk_symbol_modulator #(.DATA_WIDTH(12), .LUT_ADDR_WIDTH(4), .CLK_DIV(3),
                            .CYCLES_PER_SYMBOL(2), .DIFFERENTIAL(1)) u_b (
        .clk(clk), .rst(rst), .en_i(b_en), .sym_if(b_if), .dac_out_o(b_dac),
        .sample_stb_o(b_stb), .busy_o(b_busy), .underrun_o(b_und));

    int errors = 0;
    int checks = 0;
    logic [11:0] qa[$];
    logic [11:0] qb[$];
    logic [11:0] exp_a, exp_b;
    bit b_phase = 1'b0;

    function automatic logic [11:0] model(input int k, input bit inv);
        real v;
        logic [11:0] s;
        v = 2048.0 + 2047.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 16.0);
        s = 12'($rtoi(v + 0.5));
        if (inv) s = 12'd4095 - s;
        return s;
    endfunction

    task automatic push_a(input bit b);
        for (int i = 0; i < SYM; i++) qa.push_back(model(i % N, !b));
    endtask

    task automatic push_b(input bit b);
        b_phase = b_phase ^ b;
        for (int i = 0; i < SYM; i++) qb.push_back(model(i % N, b_phase));
    endtask

    // Scoreboards: every strobe consumes one expected sample
    always @(negedge clk) begin
        if (!rst && a_stb) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_sample: unexpected strobe dac=%0d, required no strobe", a_dac);
            end else begin
                exp_a = qa.pop_front();
                if (a_dac !== exp_a) begin
                    errors++;
                    $display("FAIL a_sample: dac=%0d, required %0d", a_dac, exp_a);
                end
            end
        end
        if (!rst && b_stb) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_sample: unexpected strobe dac=%0d, required no strobe", b_dac);
            end else begin
                exp_b = qb.pop_front();
                if (b_dac !== exp_b) begin
                    errors++;
                    $display("FAIL b_sample: dac=%0d, required %0d", b_dac, exp_b);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        a_en = 1'b0; b_en = 1'b0;
        a_if.sym_valid = 1'b0; a_if.sym_bit = 1'b0;
        b_if.sym_valid = 1'b0; b_if.sym_bit = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_dac !== 12'd2048) begin errors++; $display("FAIL reset_dac: got %0d, want 2048", a_dac); end
        checks++; if (a_if.sym_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, want 0", a_if.sym_ready); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", a_busy); end
        checks++; if (a_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b, want 0", a_stb); end
        checks++; if (a_und !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b, want 0", a_und); end
        checks++; if (b_dac !== 12'd2048) begin errors++; $display("FAIL reset_b_dac: got %0d, want 2048", b_dac); end
    endtask

    task automatic test_single_symbol();
        int strobes, unders;
        strobes = 0; unders = 0;
        @(negedge clk); #1;
        a_en = 1'b1; a_if.sym_valid = 1'b1; a_if.sym_bit = 1'b1;
        #1;
        checks++; if (a_if.sym_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b, want 1", a_if.sym_ready); end
        if (a_if.sym_valid && a_if.sym_ready) push_a(1'b1);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk); #1;
            if (k == 1) begin a_en = 1'b0; a_if.sym_valid = 1'b0; end
            if (a_stb) strobes++;
            if (a_und) unders++;
            if (k == 1) begin
                checks++; if (a_dac !== 12'd2048 || a_stb !== 1'b1) begin errors++; $display("FAIL single_t1: dac=%0d stb=%b, want 2048 stb=1", a_dac, a_stb); end
            end
            if (k == 5) begin
                checks++; if (a_dac !== 12'd4095) begin errors++; $display("FAIL single_t5: got %0d, want 4095", a_dac); end
            end
            if (k == 13) begin
                checks++; if (a_dac !== 12'd1) begin errors++; $display("FAIL single_t13: got %0d, want 1", a_dac); end
            end
        end
        checks++; if (strobes != 32) begin errors++; $display("FAIL single_strobes: got %0d, want 32", strobes); end
        checks++; if (unders != 0) begin errors++; $display("FAIL single_underrun: got %0d pulses, want 0", unders); end
        checks++; if (a_dac !== 12'd2048 || a_busy !== 1'b0) begin errors++; $display("FAIL single_idle: dac=%0d busy=%b, want 2048 0", a_dac, a_busy); end
        checks++; if (qa.size() != 0) begin errors++; $display("FAIL single_drain: %0d samples left, want 0", qa.size()); end
    endtask

    task automatic test_back_to_back();
        bit bits [3];
        int acc [3];
        int idx, readies, strobes, busy_cnt, gaps, unders;
        bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1;
        idx = 0; readies = 0; strobes = 0; busy_cnt = 0; gaps = 0; unders = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        @(negedge clk); #1;
        a_en = 1'b1; a_if.sym_valid = 1'b1; a_if.sym_bit = bits[0];
        for (int c = 0; c < 130; c++) begin
            #1;
            if (a_if.sym_ready) readies++;
            if (a_if.sym_valid && a_if.sym_ready && idx < 3) begin
                acc[idx] = c; push_a(bits[idx]); idx++;
            end
            @(negedge clk); #1;
            if (a_busy) busy_cnt++;
            if (a_busy && !a_stb) gaps++;
            if (a_und) unders++;
            if (a_stb) begin
                strobes++;
                if (strobes == 33) begin
                    checks++; if (a_dac !== 12'd2047) begin errors++; $display("FAIL b2b_s33: got %0d, want 2047", a_dac); end
                end
                if (strobes == 37) begin
                    checks++; if (a_dac !== 12'd0) begin errors++; $display("FAIL b2b_s37: got %0d, want 0", a_dac); end
                end
                if (strobes == 45) begin
                    checks++; if (a_dac !== 12'd4094) begin errors++; $display("FAIL b2b_s45: got %0d, want 4094", a_dac); end
                end
            end
            if (idx >= 3) begin a_if.sym_valid = 1'b0; a_en = 1'b0; end
            else a_if.sym_bit = bits[idx];
        end
        checks++; if (idx != 3 || readies != 3) begin errors++; $display("FAIL b2b_accepts: accepts=%0d ready_cycles=%0d, want 3 3", idx, readies); end
        checks++; if (acc[1] - acc[0] != 32 || acc[2] - acc[1] != 32) begin errors++; $display("FAIL b2b_spacing: %0d %0d, want 32 32", acc[1] - acc[0], acc[2] - acc[1]); end
        checks++; if (strobes != 96 || gaps != 0) begin errors++; $display("FAIL b2b_strobes: strobes=%0d gaps=%0d, want 96 0", strobes, gaps); end
        checks++; if (busy_cnt != 96) begin errors++; $display("FAIL b2b_busy: got %0d cycles, want 96", busy_cnt); end
        checks++; if (unders != 0) begin errors++; $display("FAIL b2b_underrun: got %0d, want 0", unders); end
    endtask

    task automatic test_underrun();
        int unders, und_k, strobes;
        unders = 0; und_k = -1; strobes = 0;
        @(negedge clk); #1;
        a_en = 1'b1; a_if.sym_valid = 1'b1; a_if.sym_bit = 1'b0;
        #1;
        if (a_if.sym_valid && a_if.sym_ready) push_a(1'b0);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk); #1;
            if (k == 1) a_if.sym_valid = 1'b0;
            if (a_stb) strobes++;
            if (a_und) begin
                unders++; und_k = k;
                checks++; if (a_dac !== 12'd2048 || a_busy !== 1'b0 || a_stb !== 1'b0) begin errors++; $display("FAIL underrun_idle: dac=%0d busy=%b stb=%b, want 2048 0 0", a_dac, a_busy, a_stb); end
            end
        end
        a_en = 1'b0;
        checks++; if (unders != 1 || und_k != 33) begin errors++; $display("FAIL underrun_pulse: pulses=%0d at=%0d, want 1 at 33", unders, und_k); end
        checks++; if (strobes != 32) begin errors++; $display("FAIL underrun_strobes: got %0d, want 32", strobes); end
    endtask

    task automatic test_differential();
        bit bits [3];
        int acc [3];
        int idx, strobes, busy_cnt, hold_err, last_c;
        logic [11:0] prev;
        bits[0] = 1'b1; bits[1] = 1'b1; bits[2] = 1'b0;
        idx = 0; strobes = 0; busy_cnt = 0; hold_err = 0; last_c = 0; prev = 12'd0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        @(negedge clk); #1;
        b_en = 1'b1; b_if.sym_valid = 1'b1; b_if.sym_bit = bits[0];
        for (int c = 0; c < 330; c++) begin
            #1;
            if (b_if.sym_valid && b_if.sym_ready && idx < 3) begin
                acc[idx] = c; push_b(bits[idx]); idx++;
            end
            @(negedge clk); #1;
            if (b_busy) busy_cnt++;
            if (b_stb) begin
                strobes++;
                if (strobes > 1 && c - last_c != 3) hold_err++;
                last_c = c;
                if (strobes == 1) begin
                    checks++; if (b_dac !== 12'd2047) begin errors++; $display("FAIL diff_s1_inv: got %0d, want 2047", b_dac); end
                end
                if (strobes == 33) begin
                    checks++; if (b_dac !== 12'd2048) begin errors++; $display("FAIL diff_s33_noninv: got %0d, want 2048", b_dac); end
                end
                if (strobes == 37) begin
                    checks++; if (b_dac !== 12'd4095) begin errors++; $display("FAIL diff_s37_noninv: got %0d, want 4095", b_dac); end
                end
                if (strobes == 69) begin
                    checks++; if (b_dac !== 12'd4095) begin errors++; $display("FAIL diff_s69_noninv: got %0d, want 4095", b_dac); end
                end
            end else if (b_busy && b_dac !== prev) begin
                hold_err++;
            end
            prev = b_dac;
            if (idx >= 3) begin b_if.sym_valid = 1'b0; b_en = 1'b0; end
            else b_if.sym_bit = bits[idx];
        end
        checks++; if (idx != 3 || acc[1] - acc[0] != 96 || acc[2] - acc[1] != 96) begin errors++; $display("FAIL diff_accepts: n=%0d spacing %0d %0d, want 3 96 96", idx, acc[1] - acc[0], acc[2] - acc[1]); end
        checks++; if (strobes != 96 || hold_err != 0) begin errors++; $display("FAIL diff_cadence: strobes=%0d hold_errs=%0d, want 96 0", strobes, hold_err); end
        checks++; if (busy_cnt != 288) begin errors++; $display("FAIL diff_busy: got %0d cycles, want 288", busy_cnt); end
        checks++; if (qb.size() != 0) begin errors++; $display("FAIL diff_drain: %0d samples left, want 0", qb.size()); end
    endtask

    task automatic test_reset_midsym();
        int strobes;
        strobes = 0;
        @(negedge clk); #1;
        a_en = 1'b1; a_if.sym_valid = 1'b1; a_if.sym_bit = 1'b0;
        #1;
        if (a_if.sym_valid && a_if.sym_ready) push_a(1'b0);
        for (int k = 1; k <= 20 && strobes < 10; k++) begin
            @(negedge clk); #1;
            a_if.sym_bit = 1'b1;
            if (a_stb) strobes++;
        end
        rst = 1'b1;
        qa.delete();
        @(negedge clk); #1;
        checks++; if (a_dac !== 12'd2048 || a_busy !== 1'b0 || a_und !== 1'b0) begin errors++; $display("FAIL midrst_state: dac=%0d busy=%b und=%b, want 2048 0 0", a_dac, a_busy, a_und); end
        rst = 1'b0;
        #1;
        checks++; if (a_if.sym_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b, want 1", a_if.sym_ready); end
        if (a_if.sym_valid && a_if.sym_ready) push_a(1'b1);
        strobes = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk); #1;
            if (k == 1) begin a_en = 1'b0; a_if.sym_valid = 1'b0; end
            if (a_stb) strobes++;
            if (k == 1) begin
                checks++; if (a_dac !== 12'd2048 || a_stb !== 1'b1) begin errors++; $display("FAIL midrst_addr0: dac=%0d stb=%b, want 2048 1", a_dac, a_stb); end
            end
            if (k == 5) begin
                checks++; if (a_dac !== 12'd4095) begin errors++; $display("FAIL midrst_addr4: got %0d, want 4095", a_dac); end
            end
        end
        checks++; if (strobes != 32 || qa.size() != 0) begin errors++; $display("FAIL midrst_symbol: strobes=%0d left=%0d, want 32 0", strobes, qa.size()); end
    endtask

    initial begin
        test_reset();
        test_single_symbol();
        test_back_to_back();
        test_underrun();
        test_differential();
        test_reset_midsym();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
